// File: rtl/stack_seq_fsm.sv
// Control-transfer sequencer: expands CALL/RET/INT/RTI into stack push/pop
// micro-steps followed by a one-cycle PC load, stalling the front end throughout.
module stack_seq_fsm #(
  parameter int PC_W       = 32,
  parameter int BUS_W      = 16,
  parameter int SAVE_FLAGS = 1,
  localparam int N_WORDS   = PC_W / BUS_W,
  localparam int IDX_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             call,
  input  logic             ret,
  input  logic             intr,
  input  logic             rti,
  input  logic             mem_ready,
  output logic             stall,
  output logic [1:0]       mem_op,
  output logic [IDX_W-1:0] word_sel,
  output logic             flags_sel,
  output logic             pc_load,
  output logic [1:0]       pc_src,
  output logic             flags_restore,
  output logic [1:0]       seq_kind
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PUSH_FLAGS = 3'd1,
    PUSH_PC    = 3'd2,
    POP_PC     = 3'd3,
    POP_FLAGS  = 3'd4,
    LOAD       = 3'd5
  } state_t;

  localparam logic [1:0] K_CALL = 2'b00;
  localparam logic [1:0] K_RET  = 2'b01;
  localparam logic [1:0] K_INT  = 2'b10;
  localparam logic [1:0] K_RTI  = 2'b11;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;

  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(N_WORDS - 1);
  localparam logic             HAS_FLAGS = (SAVE_FLAGS != 0);

  state_t           state_r, nxt_state;
  logic [IDX_W-1:0] cnt_r, nxt_cnt;
  logic [1:0]       kind_r, nxt_kind;

  logic             nxt_stall;
  logic [1:0]       nxt_mem_op;
  logic [IDX_W-1:0] nxt_word_sel;
  logic             nxt_flags_sel;
  logic             nxt_pc_load;
  logic [1:0]       nxt_pc_src;
  logic             nxt_flags_restore;

  // Next-state, word counter and sequence kind; pushes run low word first, pops high word first.
  always_comb begin
    nxt_state = state_r;
    nxt_cnt   = cnt_r;
    nxt_kind  = kind_r;
    case (state_r)
      IDLE: begin
        nxt_cnt = '0;
        if (intr) begin
          nxt_kind  = K_INT;
          nxt_state = HAS_FLAGS ? PUSH_FLAGS : PUSH_PC;
        end else if (call) begin
          nxt_kind  = K_CALL;
          nxt_state = PUSH_PC;
        end else if (ret) begin
          nxt_kind  = K_RET;
          nxt_state = POP_PC;
          nxt_cnt   = LAST_WORD;
        end else if (rti) begin
          nxt_kind  = K_RTI;
          nxt_state = POP_PC;
          nxt_cnt   = LAST_WORD;
        end else begin
          nxt_state = IDLE;
        end
      end
      PUSH_FLAGS: begin
        if (mem_ready) begin
          nxt_state = PUSH_PC;
          nxt_cnt   = '0;
        end else begin
          nxt_state = PUSH_FLAGS;
        end
      end
      PUSH_PC: begin
        if (mem_ready) begin
          if (cnt_r == LAST_WORD) begin
            nxt_state = LOAD;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt_r + IDX_W'(1);
          end
        end else begin
          nxt_state = PUSH_PC;
        end
      end
      POP_PC: begin
        if (mem_ready) begin
          if (cnt_r == '0) begin
            nxt_state = (kind_r == K_RTI && HAS_FLAGS) ? POP_FLAGS : LOAD;
          end else begin
            nxt_cnt = cnt_r - IDX_W'(1);
          end
        end else begin
          nxt_state = POP_PC;
        end
      end
      POP_FLAGS: begin
        if (mem_ready) begin
          nxt_state = LOAD;
        end else begin
          nxt_state = POP_FLAGS;
        end
      end
      LOAD: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Output decode of the upcoming state so the registered outputs track the state register.
  always_comb begin
    nxt_stall         = (nxt_state != IDLE);
    nxt_mem_op        = OP_NONE;
    nxt_word_sel      = '0;
    nxt_flags_sel     = 1'b0;
    nxt_pc_load       = 1'b0;
    nxt_pc_src        = 2'b00;
    nxt_flags_restore = 1'b0;
    case (nxt_state)
      PUSH_FLAGS: begin
        nxt_mem_op    = OP_PUSH;
        nxt_flags_sel = 1'b1;
      end
      PUSH_PC: begin
        nxt_mem_op   = OP_PUSH;
        nxt_word_sel = nxt_cnt;
      end
      POP_PC: begin
        nxt_mem_op   = OP_POP;
        nxt_word_sel = nxt_cnt;
      end
      POP_FLAGS: begin
        nxt_mem_op    = OP_POP;
        nxt_flags_sel = 1'b1;
      end
      LOAD: begin
        nxt_pc_load       = 1'b1;
        nxt_flags_restore = (nxt_kind == K_RTI);
        case (nxt_kind)
          K_CALL:  nxt_pc_src = 2'b00;
          K_INT:   nxt_pc_src = 2'b10;
          default: nxt_pc_src = 2'b01;
        endcase
      end
      default: begin
        nxt_mem_op = OP_NONE;
      end
    endcase
  end

  // State, counter, kind and all outputs registered; reset drops any partial sequence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      kind_r        <= K_CALL;
      stall         <= 1'b0;
      mem_op        <= OP_NONE;
      word_sel      <= '0;
      flags_sel     <= 1'b0;
      pc_load       <= 1'b0;
      pc_src        <= 2'b00;
      flags_restore <= 1'b0;
    end else begin
      state_r       <= nxt_state;
      cnt_r         <= nxt_cnt;
      kind_r        <= nxt_kind;
      stall         <= nxt_stall;
      mem_op        <= nxt_mem_op;
      word_sel      <= nxt_word_sel;
      flags_sel     <= nxt_flags_sel;
      pc_load       <= nxt_pc_load;
      pc_src        <= nxt_pc_src;
      flags_restore <= nxt_flags_restore;
    end
  end

  assign seq_kind = kind_r;

endmodule

// File: tb/tb_stack_seq_fsm.sv
// Bench for stack_seq_fsm: three configurations driven by shared directed stimulus,
// checked every cycle against a step-list model plus hand-computed literals.
module tb_stack_seq_fsm;

  logic clk       = 1'b0;
  logic reset     = 1'b0;
  logic call      = 1'b0;
  logic ret       = 1'b0;
  logic intr      = 1'b0;
  logic rti       = 1'b0;
  logic mem_ready = 1'b1;

  always #5 clk = ~clk;

  // u0: N_WORDS=2 with flags, u1: N_WORDS=1 with flags, u2: N_WORDS=3 without flags
  localparam int NW[3] = '{2, 1, 3};
  localparam int SF[3] = '{1, 1, 0};

  logic st0, st1, st2, fs0, fs1, fs2, ld0, ld1, ld2, fr0, fr1, fr2;
  logic ws0, ws1;
  logic [1:0] ws2;
  logic [1:0] mo0, mo1, mo2, src0, src1, src2, sk0, sk1, sk2;

  stack_seq_fsm #(.PC_W(32), .BUS_W(16), .SAVE_FLAGS(1)) u0 (
    .clk(clk), .reset(reset), .call(call), .ret(ret), .intr(intr), .rti(rti),
    .mem_ready(mem_ready), .stall(st0), .mem_op(mo0), .word_sel(ws0), .flags_sel(fs0),
    .pc_load(ld0), .pc_src(src0), .flags_restore(fr0), .seq_kind(sk0));

  stack_seq_fsm #(.PC_W(16), .BUS_W(16), .SAVE_FLAGS(1)) u1 (
    .clk(clk), .reset(reset), .call(call), .ret(ret), .intr(intr), .rti(rti),
    .mem_ready(mem_ready), .stall(st1), .mem_op(mo1), .word_sel(ws1), .flags_sel(fs1),
    .pc_load(ld1), .pc_src(src1), .flags_restore(fr1), .seq_kind(sk1));

  stack_seq_fsm #(.PC_W(48), .BUS_W(16), .SAVE_FLAGS(0)) u2 (
    .clk(clk), .reset(reset), .call(call), .ret(ret), .intr(intr), .rti(rti),
    .mem_ready(mem_ready), .stall(st2), .mem_op(mo2), .word_sel(ws2), .flags_sel(fs2),
    .pc_load(ld2), .pc_src(src2), .flags_restore(fr2), .seq_kind(sk2));

  logic       st_a[3], fs_a[3], ld_a[3], fr_a[3];
  logic [1:0] mo_a[3], ws_a[3], src_a[3], sk_a[3];
  assign st_a[0] = st0;  assign st_a[1] = st1;  assign st_a[2] = st2;
  assign fs_a[0] = fs0;  assign fs_a[1] = fs1;  assign fs_a[2] = fs2;
  assign ld_a[0] = ld0;  assign ld_a[1] = ld1;  assign ld_a[2] = ld2;
  assign fr_a[0] = fr0;  assign fr_a[1] = fr1;  assign fr_a[2] = fr2;
  assign mo_a[0] = mo0;  assign mo_a[1] = mo1;  assign mo_a[2] = mo2;
  assign ws_a[0] = {1'b0, ws0};  assign ws_a[1] = {1'b0, ws1};  assign ws_a[2] = ws2;
  assign src_a[0] = src0; assign src_a[1] = src1; assign src_a[2] = src2;
  assign sk_a[0] = sk0;  assign sk_a[1] = sk1;  assign sk_a[2] = sk2;

  typedef struct packed {
    logic [1:0] mem_op;
    logic [1:0] ws;
    logic       fs;
    logic       ld;
    logic [1:0] src;
    logic       fr;
  } step_t;

  step_t      steps[3][8];
  int         n_steps[3];
  int         pos[3];
  logic [1:0] kind_m[3];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int d, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [u%0d] at %0t: got %0h, expected %0h", nm, d, $time, act, exp);
    end
  endtask

  task automatic add(input int d, input logic [1:0] mo, input int w, input logic f,
                     input logic l, input logic [1:0] s, input logic r);
    steps[d][n_steps[d]] = {mo, 2'(w), f, l, s, r};
    n_steps[d]++;
  endtask

  // The expected micro-step list of one whole sequence, straight from the ordering rules
  task automatic build(input int d, input logic [1:0] k);
    logic [1:0] s;
    n_steps[d] = 0;
    pos[d]     = 0;
    kind_m[d]  = k;
    if (k == 2'b10 && SF[d] != 0) add(d, 2'b01, 0, 1'b1, 1'b0, 2'b00, 1'b0);
    if (k == 2'b00 || k == 2'b10) begin
      for (int w = 0; w < NW[d]; w++) add(d, 2'b01, w, 1'b0, 1'b0, 2'b00, 1'b0);
    end else begin
      for (int w = NW[d] - 1; w >= 0; w--) add(d, 2'b10, w, 1'b0, 1'b0, 2'b00, 1'b0);
    end
    if (k == 2'b11 && SF[d] != 0) add(d, 2'b10, 0, 1'b1, 1'b0, 2'b00, 1'b0);
    s = (k == 2'b00) ? 2'b00 : ((k == 2'b10) ? 2'b10 : 2'b01);
    add(d, 2'b00, 0, 1'b0, 1'b1, s, (k == 2'b11));
  endtask

  // Model advance: a memory step retires on mem_ready, the load step always retires
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        n_steps[d] = 0;
        pos[d]     = 0;
        kind_m[d]  = 2'b00;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (pos[d] < n_steps[d]) begin
          if (steps[d][pos[d]].ld || mem_ready) pos[d]++;
        end else if (intr) build(d, 2'b10);
        else if (call) build(d, 2'b00);
        else if (ret)  build(d, 2'b01);
        else if (rti)  build(d, 2'b11);
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      step_t e;
      logic  busy;
      busy = (pos[d] < n_steps[d]);
      e    = busy ? steps[d][pos[d]] : '0;
      chk("stall",         d, 8'(st_a[d]),  8'(busy));
      chk("mem_op",        d, 8'(mo_a[d]),  8'(e.mem_op));
      chk("word_sel",      d, 8'(ws_a[d]),  8'(e.ws));
      chk("flags_sel",     d, 8'(fs_a[d]),  8'(e.fs));
      chk("pc_load",       d, 8'(ld_a[d]),  8'(e.ld));
      chk("pc_src",        d, 8'(src_a[d]), 8'(e.src));
      chk("flags_restore", d, 8'(fr_a[d]),  8'(e.fr));
      chk("seq_kind",      d, 8'(sk_a[d]),  8'(kind_m[d]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((st0 || st1 || st2) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 0, 8'(st0 | st1 | st2), 8'h00);
    @(negedge clk);
  endtask

  int cnt;

  initial begin
    repeat (2) tick();
    chk("rst_stall", 0, 8'(st0), 8'h00);
    chk("rst_kind",  0, 8'(sk0), 8'h00);
    reset = 1'b1;
    tick();

    // CALL on the two-word configuration
    call = 1'b1; tick(); call = 1'b0;
    chk("call_c1_mem_op", 0, 8'(mo0), 8'h01);
    chk("call_c1_word",   0, 8'(ws0), 8'h00);
    chk("model_len_call", 0, 8'(n_steps[0]), 8'd3);
    tick();
    chk("call_c2_mem_op", 0, 8'(mo0), 8'h01);
    chk("call_c2_word",   0, 8'(ws0), 8'h01);
    tick();
    chk("call_c3_load",   0, 8'(ld0), 8'h01);
    chk("call_c3_src",    0, 8'(src0), 8'h00);
    tick();
    chk("call_c4_stall",  0, 8'(st0), 8'h00);
    wait_idle();

    // INT with the first push held off by one not-ready cycle
    intr = 1'b1; tick(); intr = 1'b0;
    chk("int_c1_flags",  0, 8'(fs0), 8'h01);
    chk("int_c1_mem_op", 0, 8'(mo0), 8'h01);
    chk("model_len_int", 0, 8'(n_steps[0]), 8'd4);
    mem_ready = 1'b0; tick();
    chk("int_c2_flags",  0, 8'(fs0), 8'h01);
    mem_ready = 1'b1;
    cnt = 2;
    repeat (6) begin
      tick();
      if (st0) cnt++;
      if (ld0) chk("int_load_src", 0, 8'(src0), 8'h02);
    end
    chk("int_stall_cycles", 0, 8'(cnt), 8'd5);
    wait_idle();

    // RTI: high word, low word, flags, then load with restore
    rti = 1'b1; tick(); rti = 1'b0;
    chk("rti_c1_pop",   0, 8'(mo0), 8'h02);
    chk("rti_c1_word",  0, 8'(ws0), 8'h01);
    tick();
    chk("rti_c2_word",  0, 8'(ws0), 8'h00);
    tick();
    chk("rti_c3_flags", 0, 8'(fs0), 8'h01);
    chk("rti_c3_pop",   0, 8'(mo0), 8'h02);
    tick();
    chk("rti_c4_load",  0, 8'(ld0), 8'h01);
    chk("rti_c4_rest",  0, 8'(fr0), 8'h01);
    chk("rti_c4_src",   0, 8'(src0), 8'h01);
    wait_idle();

    // Priority, mid-sequence request ignored, request at the LOAD edge deferred
    intr = 1'b1; call = 1'b1; ret = 1'b1; tick();
    intr = 1'b0; call = 1'b0; ret = 1'b0;
    chk("prio_kind",  0, 8'(sk0), 8'h02);
    chk("prio_flags", 0, 8'(fs0), 8'h01);
    tick();
    call = 1'b1;
    tick();
    chk("mid_kind",   0, 8'(sk0), 8'h02);
    chk("mid_word",   0, 8'(ws0), 8'h01);
    tick();
    chk("mid_load",   0, 8'(ld0), 8'h01);
    chk("mid_src",    0, 8'(src0), 8'h02);
    tick();
    chk("gap_stall",  0, 8'(st0), 8'h00);
    tick();
    call = 1'b0;
    chk("next_stall", 0, 8'(st0), 8'h01);
    chk("next_kind",  0, 8'(sk0), 8'h00);
    chk("next_word",  0, 8'(ws0), 8'h00);
    wait_idle();

    // Single-word RET on the one-word configuration
    ret = 1'b1; tick(); ret = 1'b0;
    chk("ret1_pop",  1, 8'(mo1), 8'h02);
    chk("ret1_word", 1, 8'(ws1), 8'h00);
    cnt = 0;
    repeat (6) begin
      if (st1) cnt++;
      tick();
    end
    chk("ret1_stall_cycles", 1, 8'(cnt), 8'd2);
    wait_idle();

    // Asynchronous reset in the middle of a CALL, after word 0 was pushed
    call = 1'b1; tick(); call = 1'b0;
    tick();
    chk("pre_rst_word", 0, 8'(ws0), 8'h01);
    #2 reset = 1'b0;
    #1;
    chk("arst_stall", 0, 8'(st0), 8'h00);
    chk("arst_mem_op", 0, 8'(mo0), 8'h00);
    chk("arst_word",  0, 8'(ws0), 8'h00);
    chk("arst_flags", 0, 8'(fs0), 8'h00);
    chk("arst_load",  0, 8'(ld0), 8'h00);
    chk("arst_src",   0, 8'(src0), 8'h00);
    chk("arst_rest",  0, 8'(fr0), 8'h00);
    chk("arst_kind",  0, 8'(sk0), 8'h00);
    chk("arst_stall", 2, 8'(st2), 8'h00);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_stall", 0, 8'(st0), 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_seq_fsm.md
# stack_seq_fsm

Parametrised control-transfer sequencer for the five-stage pipeline. It expands CALL, RET, INT and RTI into multi-cycle stack push/pop micro-steps: PC words, plus an optional flags word, followed by a one-cycle PC load. It stalls the front end for the whole sequence and waits on a memory-ready handshake at every stack access.

## Interface
- PC_W, 32: program counter width in bits; must be a multiple of BUS_W.
- BUS_W, 16: stack/data-memory word width; N_WORDS = PC_W/BUS_W (≥1); IDX_W = max(1, clog2(N_WORDS)).
- SAVE_FLAGS, 1: 1 = INT pushes and RTI pops one flags word; 0 = no flags access.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- call, ret, intr, rti  in  1 each  sequence requests, level, sampled only in IDLE.
- mem_ready  in  1  memory accepted or completed the current push/pop this cycle.
- stall  out  1  freeze fetch/decode; high whenever state ≠ IDLE.
- mem_op  out  2  00 none, 01 push (write), 10 pop (read).
- word_sel  out  IDX_W  index of the PC word being transferred (0 = least significant).
- flags_sel  out  1  current push/pop moves the flags word, not a PC word.
- pc_load  out  1  one-cycle strobe: write PC from pc_src.
- pc_src  out  2  00 call target, 01 popped PC, 10 interrupt vector.
- flags_restore  out  1  one-cycle strobe with pc_load, RTI only.
- seq_kind  out  2  00 CALL, 01 RET, 10 INT, 11 RTI; holds the last kind while idle.

## Operation
- States: IDLE, PUSH_FLAGS, PUSH_PC, POP_PC, POP_FLAGS, LOAD. A word counter (IDX_W bits) runs within PUSH_PC and POP_PC.
- Request acceptance in IDLE, priority intr > call > ret > rti. Only the winner is captured. Losers are dropped, and upstream holds them until stall falls.
- Requests while not IDLE are ignored.
- CALL: PUSH_PC words 0 … N_WORDS−1 (low first), then LOAD with pc_src=00.
- INT: PUSH_FLAGS (if SAVE_FLAGS), then PUSH_PC words 0 … N_WORDS−1, then LOAD with pc_src=10.
- RET: POP_PC words N_WORDS−1 … 0 (high first, LIFO), then LOAD with pc_src=01.
- RTI: POP_PC words N_WORDS−1 … 0, then POP_FLAGS (if SAVE_FLAGS), then LOAD with pc_src=01 and flags_restore=1.
- Each push/pop step holds mem_op, word_sel and flags_sel stable until a rising edge with mem_ready=1, then advances. mem_ready is ignored in IDLE and LOAD.
- LOAD lasts exactly one cycle and always returns to IDLE.
- Outputs are decoded from registered state and counter only; no input-to-output combinational path.
- N_WORDS=1: PUSH_PC and POP_PC each take a single step with word_sel=0.
- Reset (asynchronous, any state): state=IDLE, counter=0, seq_kind=00. stall, mem_op, word_sel, flags_sel, pc_load, pc_src and flags_restore are all 0 immediately. No partial sequence resumes after reset.

## Timing
- Request high at edge E0 in IDLE: the state leaves IDLE at E0, and stall is high in the cycle after E0.
- Minimum sequence length with mem_ready held at 1:
  - CALL and RET: N_WORDS+1 cycles.
  - INT and RTI: N_WORDS+1+SAVE_FLAGS cycles.
- Each mem_ready=0 cycle in a push/pop step adds exactly one cycle.
- stall falls on the edge that leaves LOAD. A request present at that same edge is not taken. The earliest new acceptance is the following edge, so there is one IDLE cycle between sequences.
- pc_load is high for exactly one cycle per sequence, and is the last stall cycle.

## Test plan
- Reset: hold reset=0 mid-sequence, after the PUSH_PC word 0 step of a CALL. All outputs are 0 immediately with no clock. After release with no request, stall stays 0.
- CALL, PC_W=32, BUS_W=16, mem_ready=1: cycle 1 mem_op=01, word_sel=0; cycle 2 mem_op=01, word_sel=1; cycle 3 pc_load=1, pc_src=00; cycle 4 stall=0.
- INT, SAVE_FLAGS=1, with mem_ready=0 in the first push cycle: PUSH_FLAGS (flags_sel=1) held 2 cycles, then PC words 0 and 1, then LOAD with pc_src=10. Total stall 5 cycles.
- RTI, SAVE_FLAGS=1: pops word_sel=1, then word_sel=0, then flags_sel=1, then pc_load=1, flags_restore=1, pc_src=01.
- Simultaneous intr=call=ret=1 in IDLE: seq_kind=10 and INT ordering. call raised mid-sequence is ignored. call held through the final LOAD edge is accepted one cycle after stall falls.
- PC_W=16, BUS_W=16 (N_WORDS=1): RET is one pop with word_sel=0 plus LOAD, giving 2 stall cycles.
